// File: rtl/shift_pipe_pkg.sv
// Shared types and helpers for the shift_pipe barrel shifter (package shift_pkg).
// The carry rule lives here so both stages agree on bit numbering.
package shift_pkg;

    typedef enum logic [1:0] {
        OP_LSL = 2'b00,
        OP_LSR = 2'b01,
        OP_ASR = 2'b10,
        OP_ROR = 2'b11
    } shift_op_t;

    localparam int unsigned MAX_W = 64;

    // Last bit shifted out, taken from the unshifted operand and full count.
    function automatic logic carry_sel(
        input logic [MAX_W-1:0] x,
        input int unsigned      w,
        input int unsigned      sc,
        input shift_op_t        op
    );
        logic       c;
        logic [5:0] idx;
        c   = 1'b0;
        idx = '0;
        if (sc != 0) begin
            if (op == OP_LSL) idx = 6'(w - sc);
            else              idx = 6'(sc - 1);
            c = x[idx];
        end
        return c;
    endfunction

endpackage

// File: rtl/shift_pipe_stage.sv
// Single mux stage of the barrel shifter: shifts by i_cnt*G in the selected mode.
// Rotate wiring exists only when SHIFT_PIPE_ROR_EN is defined; otherwise ROR acts as LSR.
module shift_stage
    import shift_pkg::*;
#(
    parameter int unsigned W  = 32,
    parameter int unsigned G  = 1,
    parameter int unsigned CW = 2
) (
    input  logic [CW-1:0] i_cnt,
    input  shift_op_t     i_op,
    input  logic [W-1:0]  i_x,
    output logic [W-1:0]  o_y
);

    localparam int unsigned AW = $clog2(W) + 1;

    logic [AW-1:0] w_amt;

    assign w_amt = AW'(i_cnt) * AW'(G);

    always_comb begin
        o_y = i_x >> w_amt;
        case (i_op)
            OP_LSL:  o_y = i_x << w_amt;
            OP_ASR:  o_y = $signed(i_x) >>> w_amt;
`ifdef SHIFT_PIPE_ROR_EN
            // Shift by W yields zero, so a zero amount rotates to the operand itself.
            OP_ROR:  o_y = (i_x >> w_amt) | (i_x << (AW'(W) - w_amt));
`endif
            default: o_y = i_x >> w_amt;
        endcase
    end

endmodule

// File: rtl/shift_pipe.sv
// Two-stage pipelined barrel shifter (LSL/LSR/ASR, ROR with SHIFT_PIPE_ROR_EN)
// with carry-out and valid/ready handshake; fine shift in stage 1, coarse in stage 2.
module shift_pipe
    import shift_pkg::*;
#(
    parameter int unsigned W   = 32,
    parameter int unsigned SCW = $clog2(W)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_x,
    input  logic [SCW-1:0] in_sc,
    input  logic [1:0]     in_op,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_y,
    output logic           out_c
);

    logic            w_s2_adv;
    logic            w_s1_adv;
    shift_op_t       w_op;
    logic            w_c;
    logic [W-1:0]    w_s1_y;
    logic [W-1:0]    w_s2_y;

    logic            r_s1_valid;
    logic [W-1:0]    r_s1_x;
    logic [SCW-3:0]  r_s1_cnt;
    shift_op_t       r_s1_op;
    logic            r_s1_c;

    logic            r_out_valid;
    logic [W-1:0]    r_out_y;
    logic            r_out_c;

    assign w_s2_adv = !r_out_valid || out_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;
    assign in_ready = w_s1_adv;

    assign w_op = shift_op_t'(in_op);
    assign w_c  = carry_sel(MAX_W'(in_x), W, 32'(in_sc), w_op);

    shift_stage #(.W(W), .G(1), .CW(2)) u_fine (
        .i_cnt (in_sc[1:0]),
        .i_op  (w_op),
        .i_x   (in_x),
        .o_y   (w_s1_y)
    );

    shift_stage #(.W(W), .G(4), .CW(SCW-2)) u_coarse (
        .i_cnt (r_s1_cnt),
        .i_op  (r_s1_op),
        .i_x   (r_s1_x),
        .o_y   (w_s2_y)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_x     <= '0;
            r_s1_cnt   <= '0;
            r_s1_op    <= OP_LSL;
            r_s1_c     <= 1'b0;
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_x   <= w_s1_y;
                r_s1_cnt <= in_sc[SCW-1:2];
                r_s1_op  <= w_op;
                r_s1_c   <= w_c;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_y     <= '0;
            r_out_c     <= 1'b0;
        end else if (w_s2_adv) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_y <= w_s2_y;
                r_out_c <= r_s1_c;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_y     = r_out_y;
    assign out_c     = r_out_c;

endmodule
